fifo_write_arbiter: RTL



---
 rtl/fifo_write_arbiter_if.sv | 30 +++
 rtl/fifo_write_arbiter.sv | 129 ++++++++++++
 2 files changed

// File: rtl/fifo_write_arbiter_if.sv
// rtl/fifo_write_arbiter_if.sv - producer-side and FIFO-side signal bundle for fifo_write_arbiter
interface fifo_write_arbiter_if #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8
);
   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]            req_last;
   logic [NUM_REQ-1:0]            req_ready;
   logic                          fifo_full;
   logic                          fifo_wr;
   logic [DATA_WIDTH-1:0]         fifo_w_data;
   logic [IDX_W-1:0]              owner;
   logic                          locked;
   logic                          timeout_err;

   // Producers and FIFO status on one side
   modport master (
      output req_valid, req_data, req_last, fifo_full,
      input  req_ready, fifo_wr, fifo_w_data, owner, locked, timeout_err
   );

   // Arbiter side
   modport slave (
      input  req_valid, req_data, req_last, fifo_full,
      output req_ready, fifo_wr, fifo_w_data, owner, locked, timeout_err
   );
endinterface

// File: rtl/fifo_write_arbiter.sv
// rtl/fifo_write_arbiter.sv - round-robin packet arbiter in front of a FIFO write port
module fifo_write_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int TIMEOUT    = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   fifo_write_arbiter_if.slave  bus
);
   // Must match the interface instance parameters.
   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [CNT_W-1:0] CNT_FIRE = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   typedef enum logic {IDLE, BURST} state_t;

   state_t                 state, state_nxt;
   logic [IDX_W-1:0]       last_grant;
   logic [IDX_W-1:0]       owner_q;
   logic                   locked_q;
   logic                   timeout_q;
   logic [CNT_W-1:0]       idle_cnt;

   logic                   win_found;
   logic [IDX_W-1:0]       win_idx;
   logic [IDX_W-1:0]       cand;
   logic [IDX_W-1:0]       grant_idx;
   logic                   idle_grant;
   logic                   owner_valid;
   logic                   owner_xfer;
   logic                   owner_done;
   logic                   idle_fire;
   logic [NUM_REQ-1:0]     ready_c;
   logic                   wr_c;
   logic [DATA_WIDTH-1:0]  data_c;
   logic [DATA_WIDTH-1:0]  words [NUM_REQ];

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign words[g] = bus.req_data[g*DATA_WIDTH +: DATA_WIDTH];
   end

   // Rotating search: the candidate nearest after last_grant wins, so scan far-to-near
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         cand = IDX_W'((int'(last_grant) + k) % NUM_REQ);
         if (bus.req_valid[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   assign owner_valid = bus.req_valid[owner_q];
   assign idle_grant  = (state == IDLE) && win_found && !bus.fifo_full;
   assign owner_xfer  = (state == BURST) && owner_valid && !bus.fifo_full;
   assign owner_done  = owner_xfer && bus.req_last[owner_q];
   // Fires on the idle cycle that brings the count up to TIMEOUT; full stalls never count
   assign idle_fire   = (TIMEOUT > 0) && (state == BURST) && !owner_valid && (idle_cnt == CNT_FIRE);
   assign grant_idx   = (state == BURST) ? owner_q : win_idx;

   // State register
   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state: multi-word packets lock the port, last word or idle timeout releases it
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (idle_grant && !bus.req_last[win_idx]) state_nxt = BURST;
         BURST:   if (owner_done || idle_fire) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs: single ready toward the granted producer, write passes straight through
   always_comb begin
      ready_c = '0;
      if (reset) begin
         if (idle_grant) begin
            ready_c[win_idx] = 1'b1;
         end else if ((state == BURST) && !bus.fifo_full) begin
            ready_c[owner_q] = 1'b1;
         end
      end
      wr_c   = |(bus.req_valid & ready_c);
      data_c = words[grant_idx];
   end

   // Grant history, owner/lock/error flags and owner idle counter
   always_ff @(posedge clk) begin
      if (!reset) begin
         last_grant <= IDX_W'(NUM_REQ - 1);
         owner_q    <= '0;
         locked_q   <= 1'b0;
         timeout_q  <= 1'b0;
         idle_cnt   <= '0;
      end else begin
         timeout_q <= idle_fire;
         locked_q  <= (state_nxt == BURST);
         if (idle_grant) begin
            owner_q <= win_idx;
            if (bus.req_last[win_idx]) last_grant <= win_idx;
         end
         if (owner_done || idle_fire) last_grant <= owner_q;
         if ((state != BURST) || owner_xfer || idle_fire) begin
            idle_cnt <= '0;
         end else if (!owner_valid && (idle_cnt != CNT_MAX)) begin
            idle_cnt <= idle_cnt + CNT_W'(1);
         end
      end
   end

   assign bus.req_ready   = ready_c;
   assign bus.fifo_wr     = wr_c;
   assign bus.fifo_w_data = data_c;
   assign bus.owner       = owner_q;
   assign bus.locked      = locked_q;
   assign bus.timeout_err = timeout_q;
endmodule
